seq_mul_16: RTL

SEQ_MUL_16 -- requirements
Module: seq_mul_16

---
 rtl/seq_mul_pkg.sv | 14 +
 rtl/Adder_16.sv | 12 +
 rtl/seq_mul_16.sv | 90 +++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the 16-bit sequential shift-and-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = 4'd15;

endpackage

// File: rtl/Adder_16.sv
// Existing 16-bit ripple-style adder block: F = A + B + Cin, Cout is the carry-out.
module Adder_16 (
  output logic [15:0] F,
  output logic        Cout,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin
);

  assign {Cout, F} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};

endmodule

// File: rtl/seq_mul_16.sv
// Iterative unsigned 16x16 multiplier: one shift-and-add step per clock, 16 steps per product.
module seq_mul_16 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  import seq_mul_pkg::*;

  state_t           r_state;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_mult;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2*W-1:0]   r_product;

  logic [W-1:0]     w_addend;
  logic [W:0]       w_sum;
  logic             w_accept;

  assign w_addend = r_mult[0] ? r_mcand : '0;
  assign w_accept = start && (r_state != RUN);

  Adder_16 u_add (
    .F    (w_sum[W-1:0]),
    .Cout (w_sum[W]),
    .A    (r_acc),
    .B    (w_addend),
    .Cin  (1'b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mult    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mcand <= a;
            r_mult  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          // 33-bit {carry, acc, mult} shifted right by one: carry lands in acc[15]
          {r_acc, r_mult} <= {w_sum, r_mult[W-1:1]};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_CNT) begin
            r_product <= {w_sum, r_mult[W-1:1]};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
